// File: rtl/barrel_shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Optional grant statistics are enabled with SHIFT_ARB_STATS_EN.
package barrel_shift_arbiter_pkg;

  localparam int DATA_W = 4;
  localparam int AMT_W  = 2;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/barrel_shift_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter
// and the result consumer.
interface barrel_shift_arbiter_if;
  import barrel_shift_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic              req0_dir;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic              req1_dir;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir,
    output req1_valid, req1_data, req1_amt, req1_dir,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir,
    input  req1_valid, req1_data, req1_amt, req1_dir,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational logical barrel shifter, zero fill in both
// directions.
module barrel_shifter
  import barrel_shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              dir_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    unique case (dir_i)
      LEFT:    data_o = data_i << amt_i;
      RIGHT:   data_o = data_i >> amt_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two requesters share one barrel shifter: grant, execute, respond.
// SHIFT_ARB_STATS_EN adds saturating per-requester grant counters.
module barrel_shift_arbiter
  import barrel_shift_arbiter_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  barrel_shift_arbiter_if.slave bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
`endif
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic [AMT_W-1:0]  op_amt_q, op_amt_d;
  logic              op_dir_q, op_dir_d;
  logic              op_id_q, op_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;

  logic              grant;
  logic              pick;
  logic [DATA_W-1:0] sh_out;

  barrel_shifter u_shifter (
    .data_i (op_data_q),
    .amt_i  (op_amt_q),
    .dir_i  (op_dir_q),
    .data_o (sh_out)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_data_d  = op_data_q;
    op_amt_d   = op_amt_q;
    op_dir_d   = op_dir_q;
    op_id_d    = op_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    grant      = 1'b0;
    pick       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant = 1'b1;
          // ptr_q names the favoured requester on contention
          if (bus.req0_valid && bus.req1_valid)
            pick = PRIO_FIXED ? 1'b0 : ptr_q;
          else
            pick = bus.req1_valid;
          op_data_d = pick ? bus.req1_data : bus.req0_data;
          op_amt_d  = pick ? bus.req1_amt  : bus.req0_amt;
          op_dir_d  = pick ? bus.req1_dir  : bus.req0_dir;
          op_id_d   = pick;
          ptr_d     = ~pick;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = sh_out;
        rsp_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      op_data_q  <= '0;
      op_amt_q   <= '0;
      op_dir_q   <= 1'b0;
      op_id_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_data_q  <= op_data_d;
      op_amt_q   <= op_amt_d;
      op_dir_q   <= op_dir_d;
      op_id_q    <= op_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign bus.req0_ready = grant & ~pick;
  assign bus.req1_ready = grant & pick;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [7:0] grant_cnt0_q, grant_cnt0_d;
  logic [7:0] grant_cnt1_q, grant_cnt1_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (bus.req0_ready && grant_cnt0_q != 8'hFF)
      grant_cnt0_d = grant_cnt0_q + 8'd1;
    if (bus.req1_ready && grant_cnt1_q != 8'hFF)
      grant_cnt1_d = grant_cnt1_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Bench for barrel_shift_arbiter: round-robin and fixed-priority
// instances checked every cycle against a transaction-level model.
module tb_barrel_shift_arbiter;
  import barrel_shift_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  barrel_shift_arbiter_if bus_rr ();
  barrel_shift_arbiter_if bus_fx ();

  logic [7:0] rr_c0, rr_c1, fx_c0, fx_c1;

  barrel_shift_arbiter #(.PRIO_FIXED(1'b0)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_cnt0 (rr_c0),
    .grant_cnt1 (rr_c1)
`endif
  );

  barrel_shift_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fx)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_cnt0 (fx_c0),
    .grant_cnt1 (fx_c1)
`endif
  );

`ifndef SHIFT_ARB_STATS_EN
  assign rr_c0 = '0;
  assign rr_c1 = '0;
  assign fx_c0 = '0;
  assign fx_c1 = '0;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Transaction-level model: one outstanding op per instance,
  // result visible two cycles after the grant cycle.
  bit         m_busy [2];
  int         m_age  [2];
  bit         m_last [2];
  logic [3:0] m_res  [2];
  logic       m_id   [2];
  int         m_c0   [2];
  int         m_c1   [2];
  int         g0     [2];
  int         g1     [2];
  bit         fixed  [2] = '{1'b0, 1'b1};
  logic [4:0] rsp_log0 [$];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] mshift(input logic [3:0] d,
                                        input logic [1:0] a,
                                        input logic dr);
    int x;
    x = int'(d);
    if (dr) x = x / (2 ** int'(a));
    else    x = (x * (2 ** int'(a))) % 16;
    return 4'(x);
  endfunction

  task automatic model_step(
    input int i,
    input logic v0, input logic v1,
    input logic [3:0] d0, input logic [3:0] d1,
    input logic [1:0] a0, input logic [1:0] a1,
    input logic dr0, input logic dr1, input logic rrdy,
    input logic o_r0, input logic o_r1, input logic o_rv,
    input logic o_rid, input logic [3:0] o_rd,
    input logic [7:0] o_c0, input logic [7:0] o_c1);
    logic w, e_r0, e_r1, e_rv;
    string p;
    p = (i == 0) ? "rr" : "fx";
    if (!rst_n) begin
      m_busy[i] = 1'b0;
      m_age[i]  = 0;
      m_last[i] = 1'b1;
      m_c0[i]   = 0;
      m_c1[i]   = 0;
      g0[i]     = 0;
      g1[i]     = 0;
      chk({p, "_rst_ready0"}, 8'(o_r0), 8'h0);
      chk({p, "_rst_ready1"}, 8'(o_r1), 8'h0);
      chk({p, "_rst_rsp_valid"}, 8'(o_rv), 8'h0);
      chk({p, "_rst_rsp_data"}, 8'(o_rd), 8'h0);
      chk({p, "_rst_rsp_id"}, 8'(o_rid), 8'h0);
`ifdef SHIFT_ARB_STATS_EN
      chk({p, "_rst_cnt0"}, o_c0, 8'h0);
      chk({p, "_rst_cnt1"}, o_c1, 8'h0);
`endif
    end else begin
      e_rv = m_busy[i] && m_age[i] >= 2;
      if (v0 && v1) w = fixed[i] ? 1'b0 : ~m_last[i];
      else          w = v1;
      e_r0 = !m_busy[i] && (v0 || v1) && !w;
      e_r1 = !m_busy[i] && (v0 || v1) && w;
      chk({p, "_ready0"}, 8'(o_r0), 8'(e_r0));
      chk({p, "_ready1"}, 8'(o_r1), 8'(e_r1));
      chk({p, "_rsp_valid"}, 8'(o_rv), 8'(e_rv));
      if (e_rv) begin
        chk({p, "_rsp_data"}, 8'(o_rd), 8'(m_res[i]));
        chk({p, "_rsp_id"}, 8'(o_rid), 8'(m_id[i]));
      end
      if (i == 0 && o_rv && rrdy) rsp_log0.push_back({o_rid, o_rd});
      if (o_r0) g0[i]++;
      if (o_r1) g1[i]++;
`ifdef SHIFT_ARB_STATS_EN
      chk({p, "_cnt0"}, o_c0, 8'(m_c0[i]));
      chk({p, "_cnt1"}, o_c1, 8'(m_c1[i]));
`endif
      if (!m_busy[i]) begin
        if (v0 || v1) begin
          m_busy[i] = 1'b1;
          m_age[i]  = 1;
          m_id[i]   = w;
          m_last[i] = w;
          m_res[i]  = w ? mshift(d1, a1, dr1) : mshift(d0, a0, dr0);
          if (!w && m_c0[i] < 255) m_c0[i]++;
          if (w && m_c1[i] < 255) m_c1[i]++;
        end
      end else if (m_age[i] >= 2) begin
        if (rrdy) m_busy[i] = 1'b0;
      end else begin
        m_age[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, bus_rr.req0_valid, bus_rr.req1_valid,
      bus_rr.req0_data, bus_rr.req1_data,
      bus_rr.req0_amt, bus_rr.req1_amt,
      bus_rr.req0_dir, bus_rr.req1_dir, bus_rr.rsp_ready,
      bus_rr.req0_ready, bus_rr.req1_ready, bus_rr.rsp_valid,
      bus_rr.rsp_id, bus_rr.rsp_data, rr_c0, rr_c1);
    model_step(1, bus_fx.req0_valid, bus_fx.req1_valid,
      bus_fx.req0_data, bus_fx.req1_data,
      bus_fx.req0_amt, bus_fx.req1_amt,
      bus_fx.req0_dir, bus_fx.req1_dir, bus_fx.rsp_ready,
      bus_fx.req0_ready, bus_fx.req1_ready, bus_fx.rsp_valid,
      bus_fx.rsp_id, bus_fx.rsp_data, fx_c0, fx_c1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_rr();
    bus_rr.req0_valid = 1'b0;
    bus_rr.req1_valid = 1'b0;
  endtask

  task automatic set_rr0(input logic [3:0] d, input logic [1:0] a,
                         input logic dr);
    bus_rr.req0_valid = 1'b1;
    bus_rr.req0_data  = d;
    bus_rr.req0_amt   = a;
    bus_rr.req0_dir   = dr;
  endtask

  task automatic set_rr1(input logic [3:0] d, input logic [1:0] a,
                         input logic dr);
    bus_rr.req1_valid = 1'b1;
    bus_rr.req1_data  = d;
    bus_rr.req1_amt   = a;
    bus_rr.req1_dir   = dr;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_rr.req0_valid = 0; bus_rr.req0_data = 0;
    bus_rr.req0_amt = 0;   bus_rr.req0_dir = 0;
    bus_rr.req1_valid = 0; bus_rr.req1_data = 0;
    bus_rr.req1_amt = 0;   bus_rr.req1_dir = 0;
    bus_rr.rsp_ready = 1;
    bus_fx.req0_valid = 0; bus_fx.req0_data = 0;
    bus_fx.req0_amt = 0;   bus_fx.req0_dir = 0;
    bus_fx.req1_valid = 0; bus_fx.req1_data = 0;
    bus_fx.req1_amt = 0;   bus_fx.req1_dir = 0;
    bus_fx.rsp_ready = 1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single op: 1011 << 1
    do_reset();
    set_rr0(4'b1011, 2'd1, LEFT);
    @(negedge clk);
    chk("t030_ready0", 8'(bus_rr.req0_ready), 8'h1);
    chk("t030_ready1", 8'(bus_rr.req1_ready), 8'h0);
    tick();
    idle_rr();
    @(negedge clk);
    chk("t030_exec_valid", 8'(bus_rr.rsp_valid), 8'h0);
    @(negedge clk);
    chk("t030_valid", 8'(bus_rr.rsp_valid), 8'h1);
    chk("t030_data", 8'(bus_rr.rsp_data), 8'h06);
    chk("t030_id", 8'(bus_rr.rsp_id), 8'h0);
    tick();
    tick();

    // contention after reset: req0 first, then req1
    do_reset();
    rsp_log0.delete();
    set_rr0(4'b1011, 2'd2, RIGHT);
    set_rr1(4'b1111, 2'd3, LEFT);
    repeat (4) tick();
    idle_rr();
    repeat (4) tick();
    chk("t031_count", 8'(rsp_log0.size()), 8'h2);
    if (rsp_log0.size() >= 2) begin
      chk("t031_first", 8'(rsp_log0[0]), 8'h02);
      chk("t031_second", 8'(rsp_log0[1]), 8'h18);
    end

    // lone req1 granted, then back-pressure on the response
    do_reset();
    bus_rr.rsp_ready = 1'b0;
    set_rr1(4'b0110, 2'd1, RIGHT);
    @(negedge clk);
    chk("t033_lone_ready1", 8'(bus_rr.req1_ready), 8'h1);
    tick();
    idle_rr();
    set_rr0(4'b0001, 2'd0, LEFT);
    @(negedge clk);
    chk("t033_exec_ready0", 8'(bus_rr.req0_ready), 8'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t033_hold_valid", 8'(bus_rr.rsp_valid), 8'h1);
      chk("t033_hold_data", 8'(bus_rr.rsp_data), 8'h03);
      chk("t033_hold_id", 8'(bus_rr.rsp_id), 8'h1);
      chk("t033_hold_ready0", 8'(bus_rr.req0_ready), 8'h0);
    end
    tick();
    bus_rr.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t033_accept_valid", 8'(bus_rr.rsp_valid), 8'h1);
    tick();
    @(negedge clk);
    chk("t033_idle_valid", 8'(bus_rr.rsp_valid), 8'h0);
    chk("t033_idle_ready0", 8'(bus_rr.req0_ready), 8'h1);
    tick();
    idle_rr();
    repeat (3) tick();

    // valid pulsed while busy is dropped, not queued
    do_reset();
    rsp_log0.delete();
    set_rr0(4'b0101, 2'd1, LEFT);
    tick();
    idle_rr();
    set_rr1(4'b1100, 2'd2, RIGHT);
    tick();
    idle_rr();
    repeat (4) tick();
    chk("t023_count", 8'(rsp_log0.size()), 8'h1);

    // reset during EXEC discards the op and clears the pointer
    do_reset();
    rsp_log0.delete();
    set_rr0(4'b1011, 2'd1, LEFT);
    @(negedge clk);
    chk("t034_ready0", 8'(bus_rr.req0_ready), 8'h1);
    tick();
    idle_rr();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t034_rst_valid", 8'(bus_rr.rsp_valid), 8'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t034_after_valid", 8'(bus_rr.rsp_valid), 8'h0);
    tick();
    set_rr0(4'b0011, 2'd1, LEFT);
    set_rr1(4'b1001, 2'd1, RIGHT);
    @(negedge clk);
    chk("t034_ptr_ready0", 8'(bus_rr.req0_ready), 8'h1);
    chk("t034_ptr_ready1", 8'(bus_rr.req1_ready), 8'h0);
    tick();
    idle_rr();
    repeat (4) tick();
    chk("t034_count", 8'(rsp_log0.size()), 8'h1);

    // mixed sweep, checked by the model only
    for (int k = 0; k < 32; k++) begin
      bus_rr.req0_valid = k[0];
      bus_rr.req0_data  = 4'(k) ^ 4'b1010;
      bus_rr.req0_amt   = 2'(k >> 1);
      bus_rr.req0_dir   = k[3];
      bus_rr.req1_valid = k[1] | k[4];
      bus_rr.req1_data  = 4'(k * 7);
      bus_rr.req1_amt   = 2'(k >> 2);
      bus_rr.req1_dir   = k[2];
      bus_rr.rsp_ready  = (k % 3) != 0;
      tick();
    end
    idle_rr();
    bus_rr.rsp_ready = 1'b1;
    repeat (4) tick();

    // fixed priority: req0 always wins
    do_reset();
    bus_fx.req0_valid = 1'b1;
    bus_fx.req0_data  = 4'b1001;
    bus_fx.req0_amt   = 2'd1;
    bus_fx.req0_dir   = RIGHT;
    bus_fx.req1_valid = 1'b1;
    bus_fx.req1_data  = 4'b0111;
    bus_fx.req1_amt   = 2'd2;
    bus_fx.req1_dir   = LEFT;
    repeat (9) tick();
    bus_fx.req0_valid = 1'b0;
    bus_fx.req1_valid = 1'b0;
    repeat (3) tick();
    chk("t032_grants0", 8'(g0[1]), 8'h3);
    chk("t032_grants1", 8'(g1[1]), 8'h0);

`ifdef SHIFT_ARB_STATS_EN
    do_reset();
    set_rr1(4'b0001, 2'd1, LEFT);
    repeat (780) tick();
    idle_rr();
    repeat (3) tick();
    chk("t035_cnt1", rr_c1, 8'd255);
    chk("t035_cnt0", rr_c0, 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 Parameter PRIO_FIXED, default 0, meaning: 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-006 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-007 req0_data / req1_data  input  4 each  operand.
REQ-008 req0_amt / req1_amt  input  2 each  shift amount 0..3.
REQ-009 req0_dir / req1_dir  input  1 each  0 = left, 1 = right.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 rsp_data  output  4  shifted result.

Function
REQ-014 The block SHALL share one barrel_shifter instance between two requesters; shifts are logical and zero-fill (1011 left 1 = 0110).
REQ-015 FSM states SHALL be IDLE, EXEC and RESP; reset state is IDLE.
REQ-016 In IDLE with at least one valid, the block SHALL grant exactly one requester: assert its ready for one cycle, capture data/amt/dir/id, and go to EXEC.
REQ-017 ready SHALL be combinational from valid and state, asserted only in IDLE, and never to both requesters in the same cycle.
REQ-018 In EXEC the block SHALL drive the captured operands into the shifter, register the output into rsp_data, and go to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1; rsp_data and rsp_id SHALL hold stable until the rsp_valid && rsp_ready edge, after which the FSM returns to IDLE.
REQ-020 Latency SHALL be: grant on edge N, rsp_valid high from cycle N+2; minimum spacing between grants is 3 cycles.
REQ-021 Round-robin (PRIO_FIXED=0): a 1-bit pointer SHALL favour the requester not granted last; it resets to favour requester 0 and updates only on a grant.
REQ-022 A lone valid requester SHALL be granted regardless of the pointer.
REQ-023 A valid that drops before grant SHALL be ignored; no operation is queued.

Reset
REQ-024 On rst_n low: state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_id = 0, both ready = 0, pointer = 0, all captured operands = 0.
REQ-025 Reset asserted in EXEC or RESP SHALL discard the operation with no response emitted.

Configuration
REQ-026 Macro SHIFT_ARB_STATS_EN, when defined, SHALL add outputs grant_cnt0 and grant_cnt1 (8 bits each, saturating at 255, reset to 0, incremented on each grant to that requester).
REQ-027 Without SHIFT_ARB_STATS_EN, those ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE/EXEC/RESP), the data width constant 4, the amount width constant 2, and the direction constants LEFT=0 and RIGHT=1.
REQ-029 The existing barrel_shifter SHALL be the single sub-module, instantiated once; the FSM and arbitration SHALL stay in barrel_shift_arbiter.

Verification
REQ-030 req0 1011, amt 1, dir 0, rsp_ready=1 -> req0_ready 1 cycle; two cycles later rsp_valid=1, rsp_data=0110, rsp_id=0.
REQ-031 Both valid after reset (req0 1011 amt 2 dir 1; req1 1111 amt 3 dir 0), both held -> first result 0010 id 0, then 1000 id 1.
REQ-032 PRIO_FIXED=1, both valid continuously for 3 operations -> all three grants go to req0; req1_ready never asserted.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp_data/rsp_id stable and both ready low throughout; IDLE one cycle after rsp_ready=1.
REQ-034 rst_n pulsed low during EXEC -> rsp_valid stays 0, pointer = 0, and the next grant with both valid goes to req0.
REQ-035 With SHIFT_ARB_STATS_EN, 260 grants to req1 -> grant_cnt1 = 255 and grant_cnt0 = 0.
